// File: rtl/sd_spi_pkg.sv
// Shared constants and types for the SD-card SPI byte engine.
package sd_spi_pkg;

  localparam int unsigned DIV_W_DEF   = 8;
  localparam int unsigned DEFAULT_DIV = 62;

  localparam logic [1:0] ADDR_DATA   = 2'd0;
  localparam logic [1:0] ADDR_STATUS = 2'd1;
  localparam logic [1:0] ADDR_CTRL   = 2'd2;
  localparam logic [1:0] ADDR_DIV    = 2'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOW  = 2'd1,
    HIGH = 2'd2
  } state_t;

endpackage

// File: rtl/sd_spi_shifter.sv
// SPI mode-0 byte shifter: 8 SD clock pulses per start, MSB first.
module sd_spi_shifter #(
  parameter int unsigned DIV_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [7:0]       tx_byte,
  input  logic [DIV_W-1:0] div,
  input  logic             sd_miso,
  output logic             busy,
  output logic [7:0]       rx_byte,
  output logic             done_c,
  output logic             sd_clk,
  output logic             sd_mosi
);
  import sd_spi_pkg::*;

  state_t           state_q, state_d;
  logic [DIV_W-1:0] half_q, half_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       tx_q, tx_d;
  logic [7:0]       rx_q, rx_d;
  logic             clk_q, clk_d;
  logic             mosi_q, mosi_d;
  logic             busy_q, busy_d;

  // State and datapath registers; reset aborts any transfer in progress.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      half_q  <= '0;
      bit_q   <= '0;
      tx_q    <= '0;
      rx_q    <= '0;
      clk_q   <= 1'b0;
      mosi_q  <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      half_q  <= half_d;
      bit_q   <= bit_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      clk_q   <= clk_d;
      mosi_q  <= mosi_d;
      busy_q  <= busy_d;
    end
  end

  // Next-state logic; each half-period lasts div+1 clk cycles, div sampled at reload.
  always_comb begin
    state_d = state_q;
    half_d  = half_q;
    bit_d   = bit_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    clk_d   = clk_q;
    mosi_d  = mosi_q;
    busy_d  = busy_q;
    done_c  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          tx_d    = tx_byte;
          mosi_d  = tx_byte[7];
          half_d  = div;
          bit_d   = 3'd0;
          busy_d  = 1'b1;
          state_d = LOW;
        end
      end
      LOW: begin
        if (half_q == '0) begin
          clk_d   = 1'b1;
          rx_d    = {rx_q[6:0], sd_miso};
          half_d  = div;
          state_d = HIGH;
        end else begin
          half_d = half_q - DIV_W'(1);
        end
      end
      HIGH: begin
        if (half_q == '0) begin
          clk_d = 1'b0;
          bit_d = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
            busy_d  = 1'b0;
            mosi_d  = 1'b1;
            done_c  = 1'b1;
            state_d = IDLE;
          end else begin
            tx_d    = {tx_q[6:0], 1'b0};
            mosi_d  = tx_q[6];
            half_d  = div;
            state_d = LOW;
          end
        end else begin
          half_d = half_q - DIV_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy    = busy_q;
  assign rx_byte = rx_q;
  assign sd_clk  = clk_q;
  assign sd_mosi = mosi_q;

endmodule

// File: rtl/sd_spi_ctrl.sv
// Avalon-MM register front end for the SD-card SPI byte engine.
module sd_spi_ctrl #(
  parameter int unsigned DIV_W       = sd_spi_pkg::DIV_W_DEF,
  parameter int unsigned DEFAULT_DIV = sd_spi_pkg::DEFAULT_DIV
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        sd_clk,
  output logic        sd_cs_n,
  output logic        sd_mosi,
  input  logic        sd_miso
);
  import sd_spi_pkg::*;

  logic             wr;
  logic             start;
  logic             busy;
  logic             done_c;
  logic [7:0]       rx_byte;
  logic [7:0]       rx_data;
  logic [DIV_W-1:0] div;
  logic             cs_n;
  logic             overrun;
  logic             unused_wdata;

  assign wr           = chipselect & ~write_n;
  assign start        = wr && (address == ADDR_DATA) && !busy;
  assign unused_wdata = ^writedata[31:8];

  // Register file: CTRL, DIV, overrun flag and the captured receive byte.
  always_ff @(posedge clk) begin
    if (reset) begin
      cs_n    <= 1'b1;
      div     <= DIV_W'(DEFAULT_DIV);
      overrun <= 1'b0;
      rx_data <= 8'h00;
    end else begin
      if (wr) begin
        unique case (address)
          ADDR_DATA:   if (busy) overrun <= 1'b1;
          ADDR_STATUS: overrun <= 1'b0;
          ADDR_CTRL:   cs_n <= writedata[0];
          ADDR_DIV:    div <= writedata[DIV_W-1:0];
          default:     ;
        endcase
      end
      if (done_c) rx_data <= rx_byte;
    end
  end

  // Zero wait-state read mux.
  always_comb begin
    readdata = 32'h0;
    unique case (address)
      ADDR_DATA:   readdata = {24'h0, rx_data};
      ADDR_STATUS: readdata = {30'h0, overrun, busy};
      ADDR_CTRL:   readdata = {31'h0, cs_n};
      ADDR_DIV:    readdata = 32'(div);
      default:     readdata = 32'h0;
    endcase
  end

  sd_spi_shifter #(.DIV_W(DIV_W)) u_shifter (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .tx_byte (writedata[7:0]),
    .div     (div),
    .sd_miso (sd_miso),
    .busy    (busy),
    .rx_byte (rx_byte),
    .done_c  (done_c),
    .sd_clk  (sd_clk),
    .sd_mosi (sd_mosi)
  );

  assign sd_cs_n = cs_n;

endmodule

// File: tb/tb_sd_spi_ctrl.sv
// Directed self-checking bench for sd_spi_ctrl.
module tb_sd_spi_ctrl;

  localparam logic [1:0] A_DATA   = 2'd0;
  localparam logic [1:0] A_STATUS = 2'd1;
  localparam logic [1:0] A_CTRL   = 2'd2;
  localparam logic [1:0] A_DIV    = 2'd3;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        sd_clk;
  logic        sd_cs_n;
  logic        sd_mosi;
  logic        sd_miso;
  logic        loopback;
  logic        miso_val;

  int tests  = 0;
  int errors = 0;

  // Pin monitor: counts SD clock pulses, high cycles, and the MOSI bit at each rise.
  int         pulses    = 0;
  int         hi_cyc    = 0;
  logic [7:0] mosi_byte = 8'h00;
  logic       prev_clk  = 1'b0;

  assign sd_miso = loopback ? sd_mosi : miso_val;

  always #5 clk = ~clk;

  sd_spi_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .sd_clk     (sd_clk),
    .sd_cs_n    (sd_cs_n),
    .sd_mosi    (sd_mosi),
    .sd_miso    (sd_miso)
  );

  always @(negedge clk) begin
    if (sd_clk === 1'b1 && prev_clk === 1'b0) begin
      pulses    = pulses + 1;
      mosi_byte = {mosi_byte[6:0], sd_mosi};
    end
    if (sd_clk === 1'b1) hi_cyc = hi_cyc + 1;
    prev_clk = sd_clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests = tests + 1;
    if (got !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Drives one write; returns 1 ns after the edge that samples it.
  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(posedge clk);
    #1;
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic reg_read(input logic [1:0] a, output logic [31:0] v);
    address    = a;
    chipselect = 1'b1;
    write_n    = 1'b1;
    #1;
    v          = readdata;
    chipselect = 1'b0;
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Counts cycles with busy set, bounded so a stuck engine cannot hang the run.
  task automatic wait_idle(output int n);
    logic [31:0] s;
    n = 0;
    forever begin
      reg_read(A_STATUS, s);
      if (s[0] !== 1'b1 || n >= 5000) break;
      tick(1);
      n = n + 1;
    end
  endtask

  task automatic run_xfer(input string tag, input logic [7:0] tx, input int div,
                          input logic [7:0] exp_rx);
    int          p0, h0, n;
    logic [31:0] v;
    p0 = pulses;
    h0 = hi_cyc;
    bus_write(A_DATA, 32'(tx));
    wait_idle(n);
    check({tag, "_busy_cycles"}, 32'(n), 32'(16 * (div + 1)));
    check({tag, "_pulses"}, 32'(pulses - p0), 32'd8);
    check({tag, "_high_cycles"}, 32'(hi_cyc - h0), 32'(8 * (div + 1)));
    check({tag, "_mosi_bits"}, 32'(mosi_byte), 32'(tx));
    reg_read(A_DATA, v);
    check({tag, "_rx_data"}, v, 32'(exp_rx));
    check({tag, "_mosi_idle"}, 32'(sd_mosi), 32'd1);
    check({tag, "_clk_idle"}, 32'(sd_clk), 32'd0);
  endtask

  initial begin
    logic [31:0] v;
    int          n, p0, guard;

    reset      = 1'b1;
    address    = 2'd0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = 32'h0;
    loopback   = 1'b1;
    miso_val   = 1'b0;
    tick(3);
    reset = 1'b0;

    // Reset state of registers and pins.
    reg_read(A_DATA, v);   check("rst_data", v, 32'h0);
    reg_read(A_STATUS, v); check("rst_status", v, 32'h0);
    reg_read(A_CTRL, v);   check("rst_ctrl", v, 32'h1);
    reg_read(A_DIV, v);    check("rst_div", v, 32'd62);
    check("rst_sd_clk", 32'(sd_clk), 32'd0);
    check("rst_sd_cs_n", 32'(sd_cs_n), 32'd1);
    check("rst_sd_mosi", 32'(sd_mosi), 32'd1);

    // Fastest divider, loopback.
    bus_write(A_DIV, 32'd0);
    reg_read(A_DIV, v); check("div0_readback", v, 32'd0);
    run_xfer("a5_div0", 8'hA5, 0, 8'hA5);

    // div=3, MISO held low.
    loopback = 1'b0;
    miso_val = 1'b0;
    bus_write(A_DIV, 32'd3);
    run_xfer("ff_div3", 8'hFF, 3, 8'h00);

    // Overrun: second DATA write while busy is dropped.
    loopback = 1'b1;
    bus_write(A_DIV, 32'd1);
    p0 = pulses;
    bus_write(A_DATA, 32'h5A);
    tick(3);
    bus_write(A_DATA, 32'h12);
    reg_read(A_STATUS, v); check("ovr_status_busy", v, 32'h3);
    wait_idle(n);
    reg_read(A_STATUS, v); check("ovr_status_done", v, 32'h2);
    reg_read(A_DATA, v);   check("ovr_rx_data", v, 32'h5A);
    check("ovr_mosi_bits", 32'(mosi_byte), 32'h5A);
    check("ovr_pulses", 32'(pulses - p0), 32'd8);
    bus_write(A_STATUS, 32'h0);
    reg_read(A_STATUS, v); check("ovr_cleared", v, 32'h0);

    // Chip select follows CTRL one cycle later, independent of the engine.
    bus_write(A_DIV, 32'd0);
    check("cs_before_write", 32'(sd_cs_n), 32'd1);
    bus_write(A_CTRL, 32'h0);
    check("cs_low", 32'(sd_cs_n), 32'd0);
    p0 = pulses;
    bus_write(A_DATA, 32'hC3);
    tick(3);
    check("cs_still_low", 32'(sd_cs_n), 32'd0);
    bus_write(A_CTRL, 32'h1);
    check("cs_high_mid", 32'(sd_cs_n), 32'd1);
    reg_read(A_CTRL, v); check("ctrl_readback", v, 32'h1);
    wait_idle(n);
    check("cs_busy_cycles", 32'(n + 4), 32'd16);
    check("cs_pulses", 32'(pulses - p0), 32'd8);
    check("cs_mosi_bits", 32'(mosi_byte), 32'hC3);
    reg_read(A_DATA, v); check("cs_rx_data", v, 32'hC3);

    // Reset during bit 4 of a transfer.
    bus_write(A_DIV, 32'd1);
    p0 = pulses;
    bus_write(A_DATA, 32'hF0);
    guard = 0;
    while ((pulses - p0) < 4 && guard < 200) begin
      tick(1);
      guard = guard + 1;
    end
    check("mid_reset_reached_bit4", 32'(pulses - p0), 32'd4);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    check("mid_reset_sd_clk", 32'(sd_clk), 32'd0);
    check("mid_reset_sd_mosi", 32'(sd_mosi), 32'd1);
    check("mid_reset_sd_cs_n", 32'(sd_cs_n), 32'd1);
    reg_read(A_STATUS, v); check("mid_reset_status", v, 32'h0);
    reg_read(A_DATA, v);   check("mid_reset_data", v, 32'h0);
    reg_read(A_DIV, v);    check("mid_reset_div", v, 32'd62);
    run_xfer("3c_default_div", 8'h3C, 62, 8'h3C);

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
